// File: rtl/ex_muldiv_iter.sv
// Iterative RV64M multiply/divide unit for the EX stage: one bit per cycle
// shift-add multiply and restoring divide on magnitudes, then a sign fix-up.
module ex_muldiv_iter #(
  parameter int XLEN = 64,
  parameter int WLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [2:0]      i_funct3,
  input  logic            i_is_word,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic            o_en_sign_ext
);

  localparam int HLEN = XLEN - WLEN;
  localparam logic [XLEN-1:0]   ONE   = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE_2 = {{(2*XLEN-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return ~v + ONE;
  endfunction

  state_t          state_r;
  logic [2:0]      op_r;
  logic            word_r;
  logic            a_neg_r;
  logic            b_neg_r;
  logic [XLEN-1:0] opnd_r;
  logic [XLEN-1:0] acc_r;
  logic [XLEN-1:0] lo_r;
  logic [6:0]      cnt_r;
  logic [XLEN-1:0] result_r;
  logic            done_r;
  logic            sext_r;

  logic [2:0]      op_s;
  logic            is_div_s;
  logic            signed_a_s;
  logic            signed_b_s;
  logic [XLEN-1:0] opa_s;
  logic [XLEN-1:0] opb_s;
  logic            a_neg_s;
  logic            b_neg_s;
  logic [XLEN-1:0] a_mag_s;
  logic [XLEN-1:0] b_mag_s;
  logic [XLEN-1:0] min_s;
  logic            div_zero_s;
  logic            div_ovf_s;
  logic [XLEN-1:0] special_raw_s;
  logic [XLEN-1:0] special_s;

  // Launch decode: narrow word operands, take magnitudes, spot division special cases.
  always_comb begin
    op_s       = (i_is_word && !i_funct3[2]) ? 3'b000 : i_funct3;
    is_div_s   = op_s[2];
    signed_a_s = (op_s != 3'b011) && (op_s != 3'b101) && (op_s != 3'b111);
    signed_b_s = signed_a_s && (op_s != 3'b010);
    opa_s = i_is_word ? {{HLEN{signed_a_s & i_rs1[WLEN-1]}}, i_rs1[WLEN-1:0]} : i_rs1;
    opb_s = i_is_word ? {{HLEN{signed_b_s & i_rs2[WLEN-1]}}, i_rs2[WLEN-1:0]} : i_rs2;
    a_neg_s = signed_a_s & opa_s[XLEN-1];
    b_neg_s = signed_b_s & opb_s[XLEN-1];
    a_mag_s = a_neg_s ? negate(opa_s) : opa_s;
    b_mag_s = b_neg_s ? negate(opb_s) : opb_s;
    min_s = i_is_word ? {{HLEN{1'b1}}, 1'b1, {(WLEN-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero_s = is_div_s && (opb_s == {XLEN{1'b0}});
    div_ovf_s  = is_div_s && signed_a_s && (opa_s == min_s) && (opb_s == {XLEN{1'b1}});
    if (div_zero_s) begin
      special_raw_s = op_s[1] ? opa_s : {XLEN{1'b1}};
    end else begin
      special_raw_s = op_s[1] ? {XLEN{1'b0}} : opa_s;
    end
    special_s = i_is_word ? {{HLEN{1'b0}}, special_raw_s[WLEN-1:0]} : special_raw_s;
  end

  logic [XLEN:0]     mul_sum_s;
  logic [XLEN:0]     div_shift_s;
  logic [XLEN:0]     div_diff_s;
  logic              div_ok_s;
  logic [2*XLEN-1:0] prod_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   raw_s;
  logic [XLEN-1:0]   fix_result_s;

  // Per-cycle iteration step and the final sign fix-up / result selection.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r} + (lo_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
    div_shift_s = {acc_r, lo_r[XLEN-1]};
    div_diff_s  = div_shift_s - {1'b0, opnd_r};
    div_ok_s    = ~div_diff_s[XLEN];
    // A word multiply has only shifted WLEN times, so the product sits WLEN bits higher.
    prod_s = word_r ? {{HLEN{1'b0}}, acc_r, lo_r[XLEN-1:HLEN]} : {acc_r, lo_r};
    prod_fix_s = (a_neg_r ^ b_neg_r) ? (~prod_s + ONE_2) : prod_s;
    quo_s = (a_neg_r ^ b_neg_r) ? negate(lo_r) : lo_r;
    rem_s = a_neg_r ? negate(acc_r) : acc_r;
    case (op_r)
      3'b000:                 raw_s = prod_fix_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: raw_s = prod_fix_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         raw_s = quo_s;
      3'b110, 3'b111:         raw_s = rem_s;
      default:                raw_s = {XLEN{1'b0}};
    endcase
    fix_result_s = word_r ? {{HLEN{1'b0}}, raw_s[WLEN-1:0]} : raw_s;
  end

  assign o_busy = rst_n & ~i_flush & ((state_r == IDLE) ? i_start : (state_r != DONE));
  assign o_done        = done_r;
  assign o_result      = result_r;
  assign o_en_sign_ext = sext_r;

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      op_r     <= 3'b000;
      word_r   <= 1'b0;
      a_neg_r  <= 1'b0;
      b_neg_r  <= 1'b0;
      opnd_r   <= {XLEN{1'b0}};
      acc_r    <= {XLEN{1'b0}};
      lo_r     <= {XLEN{1'b0}};
      cnt_r    <= 7'd0;
      result_r <= {XLEN{1'b0}};
      done_r   <= 1'b0;
      sext_r   <= 1'b0;
    end else if (i_flush) begin
      state_r <= IDLE;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (i_start) begin
            op_r    <= op_s;
            word_r  <= i_is_word;
            a_neg_r <= a_neg_s;
            b_neg_r <= b_neg_s;
            acc_r   <= {XLEN{1'b0}};
            cnt_r   <= i_is_word ? 7'd32 : 7'd64;
            opnd_r  <= is_div_s ? b_mag_s : a_mag_s;
            // Word dividends are pre-aligned so their MSB feeds the remainder first.
            if (is_div_s) begin
              lo_r <= i_is_word ? {a_mag_s[WLEN-1:0], {HLEN{1'b0}}} : a_mag_s;
            end else begin
              lo_r <= b_mag_s;
            end
            if (div_zero_s || div_ovf_s) begin
              result_r <= special_s;
              sext_r   <= i_is_word;
              done_r   <= 1'b1;
              state_r  <= DONE;
            end else begin
              state_r <= CALC;
            end
          end
        end
        CALC: begin
          if (op_r[2]) begin
            acc_r <= div_ok_s ? div_diff_s[XLEN-1:0] : div_shift_s[XLEN-1:0];
            lo_r  <= {lo_r[XLEN-2:0], div_ok_s};
          end else begin
            acc_r <= mul_sum_s[XLEN:1];
            lo_r  <= {mul_sum_s[0], lo_r[XLEN-1:1]};
          end
          cnt_r <= cnt_r - 7'd1;
          if (cnt_r == 7'd1) begin
            state_r <= FIX;
          end
        end
        FIX: begin
          result_r <= fix_result_s;
          sext_r   <= word_r;
          done_r   <= 1'b1;
          state_r  <= DONE;
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
